sync_fifo_fwft_gen: RTL

Parametrised single-clock FIFO that generalises the fixed-size PCS RX payload FIFO. It supports any power-of-two depth and data width, and a selectable read-pipeline latency. It adds a first-word-fall-through (FWFT) mode, runtime-programmable prog_empty thresholds, a synchronous flush and a live occupancy output. Storage is an internal register array with a RAM_PIPE_STAGE-cycle read pipeline, so the same control logic serves both flop and macro-style latencies.

---
 rtl/sync_fifo_fwft_gen.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/sync_fifo_fwft_gen.sv
// Single-clock FIFO with a RAM_PIPE_STAGE-cycle read pipeline and optional
// first-word-fall-through, programmable full/empty with hysteresis, flush and occupancy.
module sync_fifo_fwft_gen #(
  parameter int unsigned ADDR_WIDTH     = 7,
  parameter int unsigned DATA_WIDTH     = 72,
  parameter int unsigned RAM_PIPE_STAGE = 2,
  parameter int unsigned FWFT_EN        = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_val,
  output logic                  empty,
  output logic                  full,
  output logic                  prog_full,
  output logic                  prog_empty,
  input  logic [ADDR_WIDTH:0]   prog_full_assert_cfg,
  input  logic [ADDR_WIDTH:0]   prog_full_negate_cfg,
  input  logic [ADDR_WIDTH:0]   prog_empty_assert_cfg,
  input  logic [ADDR_WIDTH:0]   prog_empty_negate_cfg,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  ovf_int,
  output logic                  udf_int
);

  localparam int unsigned FifoDeep  = 1 << ADDR_WIDTH;
  localparam int unsigned PtrW      = ADDR_WIDTH + 1;
  localparam int unsigned SkidDepth = RAM_PIPE_STAGE + 1;
  localparam int unsigned SkidCntW  = $clog2(SkidDepth + 1);
  localparam int unsigned LastStage = RAM_PIPE_STAGE - 1;
  localparam logic [PtrW-1:0] DeepVal = PtrW'(FifoDeep);

  logic [DATA_WIDTH-1:0] mem_q [FifoDeep];
  logic [PtrW-1:0]       wptr_q, wptr_vis_q, rptr_q;
  logic [PtrW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] pipe_dat_q [RAM_PIPE_STAGE];
  logic [RAM_PIPE_STAGE-1:0] pipe_vld_q;
  logic [DATA_WIDTH-1:0] skid_dat_q [SkidDepth];
  logic [DATA_WIDTH-1:0] skid_dat_d [SkidDepth];
  logic [SkidCntW-1:0]   skid_cnt_q, skid_cnt_d;
  logic [SkidCntW-1:0]   outstanding;
  logic full_q, empty_q, pf_q, pe_q, ovf_q, udf_q;
  logic wen, pop, issue, val_out, empty_out;

  // Handshake decode: accepted write, user pop and memory read issue.
  always_comb begin
    val_out   = (FWFT_EN != 0) ? (skid_cnt_q != '0) : pipe_vld_q[LastStage];
    empty_out = (FWFT_EN != 0) ? ~val_out : empty_q;
    wen       = wr_en & ~full_q & ~flush;
    pop       = (FWFT_EN != 0) ? (rd_en & val_out & ~flush) : (rd_en & ~empty_q & ~flush);
    outstanding = '0;
    for (int i = 0; i < int'(RAM_PIPE_STAGE); i++) begin
      outstanding = outstanding + SkidCntW'(pipe_vld_q[i]);
    end
    // Prefetch credit counts the entry leaving the skid this cycle so a primed
    // skid sustains one pop per cycle without ever overfilling.
    if (FWFT_EN != 0) begin
      issue = (wptr_vis_q != rptr_q) & ~flush &
              ((int'(outstanding) + int'(skid_cnt_q) - int'(pop)) < int'(SkidDepth));
    end else begin
      issue = pop;
    end
    cnt_d = flush ? '0 : (cnt_q + PtrW'(wen) - PtrW'(pop));
  end

  // Skid buffer next state: shift out on pop, append pipeline output at the tail.
  always_comb begin
    skid_dat_d = skid_dat_q;
    skid_cnt_d = skid_cnt_q;
    if (flush) begin
      for (int i = 0; i < int'(SkidDepth); i++) skid_dat_d[i] = '0;
      skid_cnt_d = '0;
    end else if (FWFT_EN != 0) begin
      if (pop) begin
        for (int i = 0; i < int'(SkidDepth) - 1; i++) skid_dat_d[i] = skid_dat_q[i+1];
        skid_cnt_d = skid_cnt_d - SkidCntW'(1);
      end
      if (pipe_vld_q[LastStage]) begin
        for (int i = 0; i < int'(SkidDepth); i++) begin
          if (SkidCntW'(i) == skid_cnt_d) skid_dat_d[i] = pipe_dat_q[LastStage];
        end
        skid_cnt_d = skid_cnt_d + SkidCntW'(1);
      end
    end
  end

  // Storage array; no reset so it can map onto a memory macro.
  always_ff @(posedge clk) begin
    if (wen) mem_q[wptr_q[ADDR_WIDTH-1:0]] <= wr_data;
  end

  // Pointers, read pipeline, skid, occupancy and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      wptr_vis_q <= '0;
      rptr_q     <= '0;
      pipe_vld_q <= '0;
      for (int i = 0; i < int'(RAM_PIPE_STAGE); i++) pipe_dat_q[i] <= '0;
      for (int i = 0; i < int'(SkidDepth); i++) skid_dat_q[i] <= '0;
      skid_cnt_q <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      pf_q       <= 1'b0;
      pe_q       <= 1'b1;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      if (flush) begin
        // Dropping the valids discards every read still in flight.
        wptr_q     <= '0;
        wptr_vis_q <= '0;
        rptr_q     <= '0;
        pipe_vld_q <= '0;
        for (int i = 0; i < int'(RAM_PIPE_STAGE); i++) pipe_dat_q[i] <= '0;
      end else begin
        if (wen) wptr_q <= wptr_q + PtrW'(1);
        // Prefetch sees a write one cycle late, keeping it off the write path.
        wptr_vis_q <= wptr_q;
        if (issue) begin
          rptr_q        <= rptr_q + PtrW'(1);
          pipe_dat_q[0] <= mem_q[rptr_q[ADDR_WIDTH-1:0]];
        end
        pipe_vld_q[0] <= issue;
        for (int i = 1; i < int'(RAM_PIPE_STAGE); i++) begin
          pipe_vld_q[i] <= pipe_vld_q[i-1];
          if (pipe_vld_q[i-1]) pipe_dat_q[i] <= pipe_dat_q[i-1];
        end
      end
      skid_dat_q <= skid_dat_d;
      skid_cnt_q <= skid_cnt_d;
      cnt_q      <= cnt_d;
      full_q     <= (cnt_d == DeepVal);
      empty_q    <= (cnt_d == '0);
      if (flush)                               pf_q <= 1'b0;
      else if (cnt_d >= prog_full_assert_cfg)  pf_q <= 1'b1;
      else if (cnt_d < prog_full_negate_cfg)   pf_q <= 1'b0;
      if (flush)                               pe_q <= 1'b1;
      else if (cnt_d <= prog_empty_assert_cfg) pe_q <= 1'b1;
      else if (cnt_d > prog_empty_negate_cfg)  pe_q <= 1'b0;
      ovf_q <= wr_en & full_q & ~flush;
      udf_q <= rd_en & empty_out & ~flush;
    end
  end

  // Output mux: skid head in FWFT mode, pipeline tail otherwise.
  always_comb begin
    rd_data     = (FWFT_EN != 0) ? skid_dat_q[0] : pipe_dat_q[LastStage];
    rd_data_val = val_out;
    empty       = empty_out;
    full        = full_q;
    prog_full   = pf_q;
    prog_empty  = pe_q;
    data_count  = cnt_q;
    ovf_int     = ovf_q;
    udf_int     = udf_q;
  end

endmodule
